// File: rtl/tm_mem_pkg.sv
// Shared types and default geometry for the Turing machine tape/transition memory.
// Imported by the memory arbiter and by the TuringMachine top.
package tm_mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    localparam int TM_DW = 4;
    localparam int TM_W  = 64;
    localparam int TM_AW = $clog2(TM_W);

endpackage

// File: rtl/tm_rr_pick.sv
// Combinational round-robin search: first eligible requester after ptr, wrapping modulo NREQ.
// Requesters set in excl are skipped.
module tm_rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic [NREQ-1:0] excl,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   idx,
    output logic            any
);

    logic [NREQ-1:0] elig;
    logic [PW-1:0]   cand [NREQ];

    assign elig = req & ~excl;

    // cand[k] is the requester examined at priority rank k (ptr+1 is rank 0)
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            cand[k] = PW'((int'(ptr) + k + 1) % NREQ);
        end
    end

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && elig[cand[k]]) begin
                any            = 1'b1;
                idx            = cand[k];
                onehot[cand[k]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tm_mem_arbiter.sv
// Round-robin arbiter/sequencer sharing the single-port TM memory among NREQ requesters.
// Granted accesses hit the memory combinationally; read data returns one cycle later.
module tm_mem_arbiter
    import tm_mem_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int DW       = TM_DW,
    parameter int W        = TM_W,
    parameter int AW       = $clog2(W),
    parameter int MAX_HOLD = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata,
    output logic               mem_re,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata,
    output logic               busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_t      state, state_d;
    logic [PW-1:0]   owner, owner_d;
    logic [NREQ-1:0] owner_oh, owner_oh_d;
    logic [PW-1:0]   ptr, ptr_d;
    logic [HW-1:0]   hold_cnt, hold_d;

    logic [NREQ-1:0] rvalid_p1;
    logic [DW-1:0]   rdata_p1;

    logic            in_access;
    logic            own_req;
    logic            own_we;
    logic            own_lock;
    logic [AW-1:0]   own_addr;
    logic [DW-1:0]   own_wdata;
    logic            keep;

    logic [PW-1:0]   pick_ptr;
    logic [NREQ-1:0] pick_excl;
    logic [NREQ-1:0] pick_oh;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;

    assign in_access = (state == ACCESS);
    assign own_req   = req[owner];
    assign own_we    = we[owner];
    assign own_lock  = lock[owner];
    assign own_addr  = addr[owner*AW +: AW];
    assign own_wdata = wdata[owner*DW +: DW];
    assign keep      = own_lock & own_req & (hold_cnt < HOLD_LAST);

    // On release the search restarts after the outgoing owner, which is itself excluded
    assign pick_ptr  = in_access ? owner : ptr;
    assign pick_excl = in_access ? owner_oh : '0;

    tm_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .excl   (pick_excl),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= '0;
            owner_oh <= '0;
            ptr      <= PW'(NREQ - 1);
            hold_cnt <= '0;
        end else begin
            state    <= state_d;
            owner    <= owner_d;
            owner_oh <= owner_oh_d;
            ptr      <= ptr_d;
            hold_cnt <= hold_d;
        end
    end

    always_comb begin
        state_d    = state;
        owner_d    = owner;
        owner_oh_d = owner_oh;
        ptr_d      = ptr;
        hold_d     = hold_cnt;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_d    = ACCESS;
                    owner_d    = pick_idx;
                    owner_oh_d = pick_oh;
                end
            end
            ACCESS: begin
                if (keep) begin
                    hold_d = hold_cnt + 1'b1;
                end else begin
                    ptr_d  = owner;
                    hold_d = '0;
                    if (pick_any) begin
                        owner_d    = pick_idx;
                        owner_oh_d = pick_oh;
                    end else begin
                        state_d    = IDLE;
                        owner_oh_d = '0;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                owner_oh_d = '0;
            end
        endcase
    end

    always_comb begin
        gnt       = '0;
        busy      = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (in_access) begin
            gnt       = owner_oh;
            busy      = 1'b1;
            mem_re    = own_req & ~own_we;
            mem_we    = own_req & own_we;
            mem_addr  = own_addr;
            mem_wdata = own_wdata;
        end
    end

    // Read return stage: capture the bus at the edge closing the access cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rvalid_p1 <= '0;
            rdata_p1  <= '0;
        end else begin
            rvalid_p1 <= mem_re ? owner_oh : '0;
            if (mem_re) begin
                rdata_p1 <= mem_rdata;
            end
        end
    end

    assign rvalid = rvalid_p1;
    assign rdata  = rdata_p1;

endmodule

// File: tb/tb_tm_mem_arbiter.sv
// Bench for tm_mem_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_tm_mem_arbiter;

    localparam int NREQ     = 3;
    localparam int DW       = 4;
    localparam int W        = 64;
    localparam int AW       = 6;
    localparam int MAX_HOLD = 4;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ-1:0]    we = '0;
    logic [NREQ-1:0]    lock = '0;
    logic [NREQ*AW-1:0] addr = '0;
    logic [NREQ*DW-1:0] wdata = '0;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               mem_re;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;
    logic               busy;

    always #5 clock = ~clock;

    tm_mem_arbiter #(
        .NREQ     (NREQ),
        .DW       (DW),
        .W        (W),
        .AW       (AW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .lock      (lock),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Memory on the far side of the bus, written only through the DUT's enables
    logic [DW-1:0] bus_mem [W];
    logic          mem_init = 1'b1;

    function automatic logic [DW-1:0] init_word(int a);
        return DW'(a) ^ 4'hD;
    endfunction

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < W; i++) bus_mem[i] <= init_word(i);
        end else if (mem_we) begin
            bus_mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = bus_mem[mem_addr];

    // Behavioural reference: who holds the memory, rotation point, lock run length
    logic [DW-1:0]   ref_mem [W];
    bit              m_acc;
    int              m_owner;
    int              m_ptr;
    int              m_hold;
    int              m_rv;
    logic [DW-1:0]   m_rdata;
    logic [NREQ-1:0] eg_last;

    logic [NREQ-1:0] obs_gnt;
    logic [NREQ-1:0] obs_rvalid;
    logic            obs_re;
    logic            obs_we;
    logic [AW-1:0]   obs_addr;
    logic [DW-1:0]   obs_wdata;
    logic [DW-1:0]   obs_rdata;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_next(int from, logic [NREQ-1:0] r, int excl);
        for (int k = 1; k <= NREQ; k++) begin
            int c = (from + k) % NREQ;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_acc   = 1'b0;
        m_owner = 0;
        m_ptr   = NREQ - 1;
        m_hold  = 0;
        m_rv    = -1;
        m_rdata = '0;
        eg_last = '0;
    endtask

    task automatic set_rq(input int i, input int r, input int w, input int l, input int a, input int d);
        req[i]             = 1'(r);
        we[i]              = 1'(w);
        lock[i]            = 1'(l);
        addr[i*AW +: AW]   = AW'(a);
        wdata[i*DW +: DW]  = DW'(d);
    endtask

    // One clock: compare at the falling edge, advance the model, return just after the rising edge
    task automatic step();
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] erv;
        logic            ere;
        logic            ewe;
        logic [AW-1:0]   ea;
        logic [DW-1:0]   ed;
        int              w;
        @(negedge clock);
        eg = '0; ere = 1'b0; ewe = 1'b0; ea = '0; ed = '0; erv = '0;
        if (m_acc) begin
            eg  = NREQ'(1) << m_owner;
            ea  = addr[m_owner*AW +: AW];
            ed  = wdata[m_owner*DW +: DW];
            ere = req[m_owner] & ~we[m_owner];
            ewe = req[m_owner] & we[m_owner];
        end
        if (m_rv >= 0) erv = NREQ'(1) << m_rv;
        obs_gnt = gnt; obs_rvalid = rvalid; obs_re = mem_re; obs_we = mem_we;
        obs_addr = mem_addr; obs_wdata = mem_wdata; obs_rdata = rdata;
        chk("gnt", gnt, eg);
        chk("busy", busy, m_acc);
        chk("mem_re", mem_re, ere);
        chk("mem_we", mem_we, ewe);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ed);
        chk("rvalid", rvalid, erv);
        chk("rdata", rdata, m_rdata);
        eg_last = eg;
        m_rv = -1;
        if (!m_acc) begin
            w = rr_next(m_ptr, req, -1);
            if (w >= 0) begin
                m_acc   = 1'b1;
                m_owner = w;
            end
        end else begin
            if (ewe) ref_mem[ea] = ed;
            if (ere) begin
                m_rv    = m_owner;
                m_rdata = ref_mem[ea];
            end
            if (lock[m_owner] && req[m_owner] && m_hold < MAX_HOLD - 1) begin
                m_hold++;
            end else begin
                m_ptr  = m_owner;
                m_hold = 0;
                w = rr_next(m_owner, req, m_owner);
                if (w >= 0) m_owner = w;
                else m_acc = 1'b0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic hold_reset();
        req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        model_reset();
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_re", mem_re, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        @(posedge clock);
        #1;
        chk("rst_rvalid_held", rvalid, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        hold_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < W; i++) ref_mem[i] = init_word(i);
        hold_reset();
        mem_init = 1'b0;

        // Single read from requester 1 at address 7
        set_rq(1, 1, 0, 0, 7, 0);
        step();
        chk("s1_decide_gnt", obs_gnt, 0);
        step();
        chk("s1_gnt", obs_gnt, 3'b010);
        chk("s1_re", obs_re, 1);
        chk("s1_addr", obs_addr, 7);
        set_rq(1, 0, 0, 0, 0, 0);
        step();
        chk("s1_rvalid", obs_rvalid, 3'b010);
        chk("s1_rdata", obs_rdata, 4'hA);
        chk("s1_idle", obs_gnt, 0);

        // Three-way contention, no lock: 0,1,2,0 back to back
        do_reset();
        for (int i = 0; i < NREQ; i++) set_rq(i, 1, 0, 0, 10 + i, 0);
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("s2_order", obs_gnt, 32'(1 << (k % NREQ)));
        end
        req = '0;
        step();
        step();

        // Lock held by 0 with 2 waiting: four grants to 0, then 2
        do_reset();
        set_rq(0, 1, 0, 1, 3, 0);
        set_rq(2, 1, 0, 0, 9, 0);
        step();
        for (int k = 0; k < MAX_HOLD; k++) begin
            step();
            chk("s3_hold", obs_gnt, 3'b001);
        end
        step();
        chk("s3_forced", obs_gnt, 3'b100);
        set_rq(2, 0, 0, 0, 0, 0);
        step();
        set_rq(0, 0, 0, 0, 0, 0);
        step();
        step();

        // Owner withdraws its request in its access cycle
        do_reset();
        set_rq(0, 1, 0, 0, 4, 0);
        set_rq(1, 1, 0, 0, 6, 0);
        step();
        set_rq(0, 0, 0, 0, 0, 0);
        step();
        chk("s4_gnt", obs_gnt, 3'b001);
        chk("s4_re", obs_re, 0);
        chk("s4_we", obs_we, 0);
        step();
        chk("s4_no_rvalid", obs_rvalid, 0);
        chk("s4_next", obs_gnt, 3'b010);
        set_rq(1, 0, 0, 0, 0, 0);
        step();
        step();

        // Read-modify-write of word 5 under lock
        do_reset();
        set_rq(1, 1, 0, 1, 5, 0);
        step();
        step();
        chk("s5_rd_gnt", obs_gnt, 3'b010);
        chk("s5_rd_re", obs_re, 1);
        set_rq(1, 1, 1, 0, 5, 3);
        step();
        chk("s5_wr_gnt", obs_gnt, 3'b010);
        chk("s5_wr_we", obs_we, 1);
        chk("s5_wr_addr", obs_addr, 5);
        chk("s5_wr_data", obs_wdata, 3);
        chk("s5_rd_rvalid", obs_rvalid, 3'b010);
        chk("s5_rd_rdata", obs_rdata, 4'h8);
        set_rq(1, 0, 0, 0, 0, 0);
        step();
        chk("s5_mem5", bus_mem[5], 3);

        // Reset in the middle of a read access
        do_reset();
        set_rq(1, 1, 0, 0, 7, 0);
        step();
        #3;
        reset = 1'b1;
        #1;
        chk("s6_gnt", gnt, 0);
        chk("s6_re", mem_re, 0);
        chk("s6_busy", busy, 0);
        hold_reset();
        for (int i = 0; i < NREQ; i++) set_rq(i, 1, 0, 0, 20 + i, 0);
        step();
        step();
        chk("s6_first", obs_gnt, 3'b001);
        req = '0;
        step();
        step();

        // Random traffic; fields only change when idle or right after a grant
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (eg_last[i]) begin
                        if ($urandom_range(0, 1) == 0) set_rq(i, 0, 0, 0, 0, 0);
                        else set_rq(i, 1, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                                    int'($urandom_range(0, W - 1)), int'($urandom_range(0, 15)));
                    end
                end else if ($urandom_range(0, 9) < 4) begin
                    set_rq(i, 1, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                           int'($urandom_range(0, W - 1)), int'($urandom_range(0, 15)));
                end
            end
            step();
        end
        req = '0;
        lock = '0;
        step();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/tm_mem_arbiter.md
Name: tm_mem_arbiter

Overview:
Round-robin arbiter and sequencer for the Turing machine's single-port tape/transition memory. It shares that memory between up to NREQ requesters: the input loader, the TM core and the tape display scanner. Each requester sees a simple req/gnt/rvalid handshake. The arbiter drives the memory's re/we/addr and write data; the external BusDriver handles the tri-state bus.

Parameters:
NREQ, 3, number of requesters (2..4)
DW, 4, memory word width
W, 64, memory depth in words
AW, $clog2(W), address width
MAX_HOLD, 4, maximum consecutive granted accesses under lock before a forced release

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester access request; held until granted
we  input  NREQ  per-requester write (1) / read (0)
lock  input  NREQ  owner asks to keep the grant for its next access (read-modify-write)
addr  input  NREQ*AW  packed addresses; requester i occupies [i*AW +: AW]
wdata  input  NREQ*DW  packed write data; requester i occupies [i*DW +: DW]
gnt  output  NREQ  one-hot; the access is performed in the cycle gnt[i]=1
rvalid  output  NREQ  one-cycle pulse the cycle after a granted read
rdata  output  DW  registered read data, valid with rvalid
mem_re  output  1  memory read enable
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  DW  data to the BusDriver
mem_rdata  input  DW  data sampled from the memory bus
busy  output  1  high while any grant is active

Behaviour:
- Reset (async): state IDLE, owner=0, ptr=NREQ-1 (so requester 0 wins first), hold_cnt=0. gnt, rvalid, rdata, mem_re, mem_we, mem_addr, mem_wdata and busy are all 0.
- States: IDLE, ACCESS.
- IDLE: if any req bit is high, the winner is the first set bit searching ptr+1, ptr+2, ... modulo NREQ. The winner is registered as owner, the state goes to ACCESS, and gnt becomes one-hot the next cycle. The decision costs one cycle.
- ACCESS:
  - gnt[owner]=1 and busy=1.
  - mem_addr and mem_wdata are driven combinationally from the owner's slice.
  - mem_we = req[owner] & we[owner]; mem_re = req[owner] & ~we[owner].
  - If req[owner] is low, the access is cancelled: no enables, no rvalid.
- Read: mem_rdata is captured into rdata at the clock edge ending the ACCESS cycle. rvalid[owner] pulses for exactly one cycle after it. Read latency from grant is 1 cycle. rdata holds its value until the next read.
- Next state at the end of an ACCESS cycle:
  - If lock[owner] & req[owner] and hold_cnt < MAX_HOLD-1: stay in ACCESS with the same owner and increment hold_cnt.
  - Otherwise release: ptr <= owner and hold_cnt <= 0. If any other requester (owner excluded) has req high, pick the next winner round-robin from the new ptr and stay in ACCESS (back-to-back grant, no bubble). Otherwise go to IDLE and drop gnt.
  - A forced release at MAX_HOLD happens even with lock high. The former owner may re-win only after the others have been served in rotation.
- Simultaneous requests: round-robin order is strict. No requester waits more than NREQ-1 grants (MAX_HOLD accesses each under lock).
- Requester contract: addr, we and wdata are stable while req is high and gnt is low. The requester samples gnt to advance.
- hold_cnt saturates at MAX_HOLD-1 and is $clog2(MAX_HOLD)+1 bits wide. ptr and owner are $clog2(NREQ) bits. Modulo arithmetic wraps NREQ-1 -> 0.
- Reset mid-access: outputs clear immediately (async). Any in-flight read produces no rvalid.

Decomposition:
- Package tm_mem_pkg: arb_state_t enum {IDLE, ACCESS} and the DW/AW defaults shared with the TuringMachine top.
- Sub-module tm_rr_pick: combinational round-robin first-set search.
  - Inputs: req vector, ptr, and an exclude mask.
  - Outputs: one-hot winner, winner index, any.

Test Plan:
- Single read: req[1]=1, we=0, addr=7, memory word 7=4'hA. Expect gnt[1] in cycle 2, mem_re=1 with mem_addr=7, then rvalid[1]=1 and rdata=4'hA in cycle 3, then IDLE.
- Three-way contention: req=3'b111 held continuously, no lock. Expect grant order 0,1,2,0 with back-to-back gnt (no IDLE cycles between grants).
- Lock and forced release: req[0]=1, lock[0]=1 held, with req[2]=1 also pending. Expect gnt[0] for exactly 4 consecutive cycles, then gnt[2].
- Cancelled access: owner drops req in its ACCESS cycle. Expect mem_re=mem_we=0, no rvalid, and release to the next requester.
- Read-modify-write: lock[1]=1 for a read at address 5, then a write of 4'h3 at address 5. Expect the write issued the cycle after the read with the same owner and memory word 5 = 3.
- Async reset asserted during an ACCESS read: expect gnt=0, mem_re=0 and no rvalid. After release, the first winner is requester 0.
